// File: rtl/ip_ctrl_pkg.sv
// Shared types and helpers for the inner-product lane sequencer.
package ip_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned DEF_RD_LAT = 1;
    localparam int unsigned DRAIN_LAT  = DEF_RD_LAT + 1;

    // Replicates bit w-1 of v into every bit above it; callers cast to their width.
    function automatic logic [63:0] sign_extend(input logic [63:0] v, input int unsigned w);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            r[i] = (i < w) ? v[i] : v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/ip_valid_pipe.sv
// Valid shift register: rd_en delayed DEPTH cycles gives sel, one more gives acc_en.
module ip_valid_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic sel,
    output logic acc_en
);

    if (DEPTH == 0) begin : g_nodelay
        assign sel = in_valid;
    end else begin : g_delay
        logic [DEPTH-1:0] sr;
        always_ff @(posedge clk) begin
            if (rst) begin
                sr <= '0;
            end else begin
                sr[0] <= in_valid;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end
        assign sel = sr[DEPTH-1];
    end

    // Extra stage mirrors the ip stage's output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_en <= 1'b0;
        end else begin
            acc_en <= sel;
        end
    end

endmodule

// File: rtl/ip_seq_ctrl.sv
// Sequencer for one inner-product lane: issues chunk reads, accumulates ip stage
// partial sums into a dot product and hands it out on a valid/ready handshake.
module ip_seq_ctrl
    import ip_ctrl_pkg::*;
#(
    parameter int unsigned BITWIDTH = 16,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned CNT_W    = 9,
    parameter int unsigned RD_LAT   = DEF_RD_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_chunks,
    output logic                busy,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                sel,
    input  logic [BITWIDTH-1:0] ip_sum,
    output logic [ACC_W-1:0]    result,
    output logic                result_valid,
    input  logic                result_ready
);

    localparam int unsigned FL_W = $clog2(RD_LAT + 2);

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ip_ext;
    logic [FL_W-1:0]  inflight;
    logic             acc_en;
    logic             last_addr;

    ip_valid_pipe #(.DEPTH(RD_LAT)) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_en),
        .sel      (sel),
        .acc_en   (acc_en)
    );

    always_comb begin
        ip_ext    = ACC_W'(sign_extend(64'(ip_sum), BITWIDTH));
        last_addr = (CNT_W'(rd_addr) == (n_lat - CNT_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            acc          <= '0;
            n_lat        <= '0;
            inflight     <= '0;
        end else begin
            if (acc_en) begin
                acc <= acc + ip_ext;
            end

            case ({rd_en, acc_en})
                2'b10:   inflight <= inflight + FL_W'(1);
                2'b01:   inflight <= inflight - FL_W'(1);
                default: inflight <= inflight;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat   <= num_chunks;
                        acc     <= '0;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        if (num_chunks == '0) begin
                            state        <= DONE;
                            result       <= '0;
                            result_valid <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            rd_en <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_addr) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Last partial sum lands in acc on the edge that empties inflight.
                    if (inflight == '0) begin
                        state        <= DONE;
                        result       <= acc;
                        result_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_seq_ctrl.sv
// Directed bench for ip_seq_ctrl with a behavioural registered ip stage per DUT.
module tb_ip_seq_ctrl;

    localparam int BW  = 16;
    localparam int AW  = 32;
    localparam int ADW = 8;
    localparam int CW  = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           result_ready = 1'b0;
    logic [CW-1:0]  num_chunks = '0;
    logic           busy, rd_en, sel, result_valid;
    logic [ADW-1:0] rd_addr;
    logic [BW-1:0]  ip_sum = '0;
    logic [AW-1:0]  result;

    logic           start16 = 1'b0;
    logic           result_ready16 = 1'b0;
    logic [CW-1:0]  num16 = '0;
    logic           busy16, rd_en16, sel16, result_valid16;
    logic [ADW-1:0] rd_addr16;
    logic [BW-1:0]  ip_sum16 = '0;
    logic [15:0]    result16;

    int checks = 0;
    int fails  = 0;

    logic [15:0] feed[$];
    logic [15:0] feed16[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (sel && feed.size() > 0) ip_sum <= feed.pop_front();
    always @(posedge clk) if (sel16 && feed16.size() > 0) ip_sum16 <= feed16.pop_front();

    ip_seq_ctrl #(.BITWIDTH(BW), .ACC_W(AW), .ADDR_W(ADW), .CNT_W(CW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .sel(sel), .ip_sum(ip_sum), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    ip_seq_ctrl #(.BITWIDTH(BW), .ACC_W(16), .ADDR_W(ADW), .CNT_W(CW), .RD_LAT(1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .num_chunks(num16), .busy(busy16),
        .rd_en(rd_en16), .rd_addr(rd_addr16), .sel(sel16), .ip_sum(ip_sum16), .result(result16),
        .result_valid(result_valid16), .result_ready(result_ready16)
    );

    // Caller is positioned #1 after an edge; returns #1 after the sampling edge.
    task automatic do_start(input logic [CW-1:0] n);
        start = 1'b1;
        num_chunks = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until result_valid, recording the read sequence.
    task automatic wait_done(output int cyc, output int rds, output logic addr_ok);
        cyc = 0; rds = 0; addr_ok = 1'b1;
        while (!result_valid && cyc < 100) begin
            if (rd_en) begin
                if (rd_addr !== ADW'(rds)) addr_ok = 1'b0;
                rds++;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, rd_en, sel, result_valid, rd_addr, result} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b rd_en=%b sel=%b rv=%b addr=%0d result=%h expected all 0",
                     busy, rd_en, sel, result_valid, rd_addr, result);
        end
        checks++;
        if ({busy16, result_valid16, result16} !== '0) begin
            fails++;
            $display("FAIL reset_outputs16: got busy=%b rv=%b result=%h expected all 0", busy16, result_valid16, result16);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, rds; logic ok;
        feed = '{16'd1, 16'd2, 16'd3, 16'd4};
        do_start(9'd4);
        wait_done(cyc, rds, ok);
        checks++; if (cyc !== 7) begin fails++; $display("FAIL basic_latency: got %0d expected 7", cyc); end
        checks++; if (rds !== 4) begin fails++; $display("FAIL basic_reads: got %0d expected 4", rds); end
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_addr_seq: got %b expected 1", ok); end
        checks++; if (result !== 32'd10) begin fails++; $display("FAIL basic_result: got %h expected %h", result, 32'd10); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", busy); end
        accept();
        checks++;
        if ({result_valid, busy} !== 2'b00) begin
            fails++; $display("FAIL basic_after_accept: got rv/busy=%b expected 00", {result_valid, busy});
        end
        checks++; if (rd_addr !== 8'd3) begin fails++; $display("FAIL basic_addr_hold: got %0d expected 3", rd_addr); end
    endtask

    task automatic test_zero();
        int cyc, rds; logic ok;
        do_start(9'd0);
        wait_done(cyc, rds, ok);
        checks++; if (cyc !== 0) begin fails++; $display("FAIL zero_latency: got %0d expected 0", cyc); end
        checks++; if (rds !== 0) begin fails++; $display("FAIL zero_reads: got %0d expected 0", rds); end
        checks++; if (result !== 32'd0) begin fails++; $display("FAIL zero_result: got %h expected 0", result); end
        accept();
    endtask

    task automatic test_negative();
        int cyc, rds; logic ok;
        feed = '{16'h8000, 16'h8000, 16'h8000};
        do_start(9'd3);
        wait_done(cyc, rds, ok);
        checks++; if (cyc !== 6) begin fails++; $display("FAIL neg_latency: got %0d expected 6", cyc); end
        checks++;
        if (result !== 32'hFFFE8000) begin fails++; $display("FAIL neg_result: got %h expected FFFE8000", result); end
        accept();
    endtask

    task automatic test_wrap16();
        int cyc;
        feed16 = '{16'h7FFF, 16'h7FFF};
        start16 = 1'b1; num16 = 9'd2;
        @(posedge clk); #1;
        start16 = 1'b0;
        cyc = 0;
        while (!result_valid16 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc !== 5) begin fails++; $display("FAIL wrap_latency: got %0d expected 5", cyc); end
        checks++; if (result16 !== 16'hFFFE) begin fails++; $display("FAIL wrap_result: got %h expected FFFE", result16); end
        result_ready16 = 1'b1;
        @(posedge clk); #1;
        result_ready16 = 1'b0;
        checks++; if (result_valid16 !== 1'b0) begin fails++; $display("FAIL wrap_accept: got %b expected 0", result_valid16); end
    endtask

    task automatic test_hold();
        int cyc, rds; logic ok;
        feed = '{16'd3, 16'd4};
        do_start(9'd2);
        wait_done(cyc, rds, ok);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({result_valid, busy, rd_en, result} !== {1'b1, 1'b1, 1'b0, 32'd7}) begin
                fails++;
                $display("FAIL hold_cycle%0d: got rv=%b busy=%b rd_en=%b result=%h expected 1 1 0 00000007",
                         i, result_valid, busy, rd_en, result);
            end
            if (i == 2) begin start = 1'b1; num_chunks = 9'd3; end
            @(posedge clk); #1;
            start = 1'b0;
        end
        accept();
        @(posedge clk); #1;
        checks++;
        if ({busy, rd_en, result_valid} !== 3'b000) begin
            fails++; $display("FAIL hold_start_ignored: got busy/rd_en/rv=%b expected 000", {busy, rd_en, result_valid});
        end
    endtask

    task automatic test_reset_mid();
        int cyc, rds, guard; logic ok;
        feed = '{16'd1, 16'd2, 16'd3, 16'd4};
        do_start(9'd4);
        guard = 0;
        while (!(rd_en && rd_addr == 8'd2) && guard < 20) begin @(posedge clk); #1; guard++; end
        checks++; if (guard >= 20) begin fails++; $display("FAIL rstmid_reach_addr2: got timeout expected addr 2"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, rd_en, sel, result_valid, rd_addr, result} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got busy=%b rd_en=%b sel=%b rv=%b addr=%0d result=%h expected all 0",
                     busy, rd_en, sel, result_valid, rd_addr, result);
        end
        feed.delete();
        feed = '{16'd5, 16'd6};
        do_start(9'd2);
        wait_done(cyc, rds, ok);
        checks++; if (result !== 32'd11) begin fails++; $display("FAIL rstmid_rerun: got %h expected %h", result, 32'd11); end
        accept();
    endtask

    task automatic test_back_to_back();
        int cyc, rds; logic ok;
        feed = '{16'd2, 16'd3, 16'd4, 16'd7};
        do_start(9'd3);
        wait_done(cyc, rds, ok);
        checks++; if (result !== 32'd9) begin fails++; $display("FAIL b2b_first: got %h expected %h", result, 32'd9); end
        accept();
        do_start(9'd1);
        wait_done(cyc, rds, ok);
        checks++; if (cyc !== 4) begin fails++; $display("FAIL b2b_latency: got %0d expected 4", cyc); end
        checks++; if (result !== 32'd7) begin fails++; $display("FAIL b2b_second: got %h expected %h", result, 32'd7); end
        accept();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_negative();
        test_wrap16();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
